// File: rtl/neuron_mac_seq_pkg.sv
// Shared definitions for the neuron MAC sequencer: datapath width and FSM encodings.
package neuron_mac_seq_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    NMS_IDLE  = 2'd0,
    NMS_ISSUE = 2'd1,
    NMS_DRAIN = 2'd2,
    NMS_DONE  = 2'd3
  } nms_state_e;

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Control, buffer-read, multiply-return and result handshake bundle of the MAC sequencer.
interface neuron_mac_seq_if
  import neuron_mac_seq_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = 8
);
  logic                 start;
  logic                 abort;
  logic [AW:0]          num_in;
  logic                 busy;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic                 df_rdy;
  logic                 mu_rdy;
  logic signed [DW-1:0] mu_out;
  logic signed [DW-1:0] acc_out;
  logic                 acc_vld;
  logic                 acc_ack;
  logic                 ovf;

  modport master (
    output start, abort, num_in, mu_rdy, mu_out, acc_ack,
    input  busy, rd_en, rd_addr, df_rdy, acc_out, acc_vld, ovf
  );

  modport slave (
    input  start, abort, num_in, mu_rdy, mu_out, acc_ack,
    output busy, rd_en, rd_addr, df_rdy, acc_out, acc_vld, ovf
  );
endinterface

// File: rtl/neuron_mac_seq_sat_acc.sv
// Signed saturating accumulator: clear has priority over enable, ovf is sticky until clear.
module neuron_mac_seq_sat_acc #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] acc,
  output logic                 ovf
);
  localparam logic signed [DW-1:0] ACC_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] ACC_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW:0] sum;

  // One guard bit: the two top bits disagree exactly when the sum left the DW range.
  assign sum = {acc[DW-1], acc} + {din[DW-1], din};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (sum[DW] != sum[DW-1]) begin
        acc <= sum[DW] ? ACC_MIN : ACC_MAX;
        ovf <= 1'b1;
      end else begin
        acc <= sum[DW-1:0];
      end
    end
  end
endmodule

// File: rtl/neuron_mac_seq.sv
// Multiply-accumulate pass sequencer: issues N buffer reads, accumulates returned
// products with saturation and presents the sum on a valid/ack handshake.
module neuron_mac_seq
  import neuron_mac_seq_pkg::*;
#(
  parameter int DW     = DATA_WIDTH,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  neuron_mac_seq_if.slave bus
);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  nms_state_e           state;
  logic [AW:0]          n_lat;
  logic [AW:0]          issue_cnt;
  logic [AW:0]          prod_cnt;
  logic [AW:0]          prod_inc;
  logic                 rd_en_q;
  logic [AW-1:0]        rd_addr_q;
  logic                 acc_vld_q;
  logic [RD_LAT-1:0]    vld_pipe;
  logic                 acc_clr;
  logic                 acc_en;
  logic signed [DW-1:0] acc;
  logic                 acc_ovf;

  assign acc_clr  = (state == NMS_IDLE) && bus.start && !bus.abort;
  assign acc_en   = bus.mu_rdy && !bus.abort &&
                    ((state == NMS_ISSUE) || (state == NMS_DRAIN));
  assign prod_inc = prod_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= NMS_IDLE;
      n_lat     <= '0;
      issue_cnt <= '0;
      prod_cnt  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      acc_vld_q <= 1'b0;
    end else if (bus.abort) begin
      state     <= NMS_IDLE;
      rd_en_q   <= 1'b0;
      acc_vld_q <= 1'b0;
    end else begin
      case (state)
        NMS_IDLE: if (bus.start) begin
          n_lat     <= bus.num_in;
          prod_cnt  <= '0;
          rd_addr_q <= '0;
          if (bus.num_in != '0) begin
            state     <= NMS_ISSUE;
            rd_en_q   <= 1'b1;
            issue_cnt <= CNT_ONE;
          end else begin
            state     <= NMS_DONE;
            issue_cnt <= '0;
          end
        end
        NMS_ISSUE: begin
          if (bus.mu_rdy) prod_cnt <= prod_inc;
          if (issue_cnt == n_lat) begin
            rd_en_q <= 1'b0;
            state   <= NMS_DRAIN;
          end else begin
            issue_cnt <= issue_cnt + CNT_ONE;
            rd_addr_q <= rd_addr_q + ADDR_ONE;
          end
        end
        NMS_DRAIN: if (bus.mu_rdy) begin
          prod_cnt <= prod_inc;
          if (prod_inc >= n_lat) begin
            state     <= NMS_DONE;
            acc_vld_q <= 1'b1;
          end
        end
        NMS_DONE: begin
          // An empty pass enters DONE with valid low and raises it one cycle later.
          acc_vld_q <= 1'b1;
          if (acc_vld_q && bus.acc_ack) begin
            acc_vld_q <= 1'b0;
            state     <= NMS_IDLE;
          end
        end
        default: state <= NMS_IDLE;
      endcase
    end
  end

  // Operand-valid tracks the buffer read latency so mu_reg latches live data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else if (bus.abort) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  neuron_mac_seq_sat_acc #(.DW(DW)) u_sat_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (bus.mu_out),
    .acc   (acc),
    .ovf   (acc_ovf)
  );

  assign bus.busy    = (state != NMS_IDLE);
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.df_rdy  = vld_pipe[RD_LAT-1];
  assign bus.acc_out = acc;
  assign bus.acc_vld = acc_vld_q;
  assign bus.ovf     = acc_ovf;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a behavioural buffer + mu_reg model (DW=8, AW=8, RD_LAT=1).
module tb_neuron_mac_seq;
  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  neuron_mac_seq_if #(.DW(DW), .AW(AW)) bus ();

  neuron_mac_seq #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Buffer (1-cycle read) followed by mu_reg (registers on df_rdy).
  logic signed [7:0] prod_mem [256];
  logic [AW-1:0]     a_d     = '0;
  logic              mdl_rdy = 1'b0;
  logic signed [7:0] mdl_out = '0;
  logic              inj_rdy = 1'b0;
  logic signed [7:0] inj_val = '0;

  always @(posedge clk) begin
    a_d     <= bus.rd_addr;
    mdl_rdy <= bus.df_rdy;
    mdl_out <= prod_mem[a_d];
  end

  assign bus.mu_rdy = mdl_rdy | inj_rdy;
  assign bus.mu_out = inj_rdy ? inj_val : mdl_out;

  // Read-strobe monitor: counts issues and address-sequence errors.
  int rd_cnt = 0, addr_err = 0, mon_addr = 0;
  bit prev_rd = 1'b0;
  always @(posedge clk) begin
    if (bus.rd_en) begin
      if (!prev_rd) mon_addr = 0;
      if (bus.rd_addr !== 8'(mon_addr)) addr_err++;
      mon_addr++;
      rd_cnt++;
    end
    prev_rd = bus.rd_en;
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    n;
    int    p [4];
    int    exp_acc;
    bit    exp_ovf;
  } vec_t;

  function automatic vec_t mk(string nm, int n, int p0, int p1, int p2, int p3, int acc, bit ovf);
    vec_t v;
    v.name = nm; v.n = n;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.exp_acc = acc; v.exp_ovf = ovf;
    return v;
  endfunction

  function automatic int exp_lat(int n);
    return (n == 0) ? 2 : n + RD_LAT + 2;
  endfunction

  // Start a pass, wait (bounded) for acc_vld, check result/latency/issue pattern, optionally ack.
  task automatic run_pass(input string name, input int n, input int exp_acc, input bit exp_ovf, input bit do_ack);
    int lat = 0;
    int r0 = rd_cnt;
    int e0 = addr_err;
    @(negedge clk);
    bus.num_in = 9'(n);
    bus.start  = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.num_in = 9'(n ^ 5);
    end while (!bus.acc_vld && lat < 600);
    chk({name, "_lat"},   lat, exp_lat(n));
    chk({name, "_acc"},   bus.acc_out, exp_acc);
    chk({name, "_ovf"},   bus.ovf, 32'(exp_ovf));
    chk({name, "_rdcnt"}, rd_cnt - r0, n);
    chk({name, "_addr"},  addr_err - e0, 0);
    chk({name, "_busy"},  bus.busy, 1);
    if (do_ack) begin
      bus.acc_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.acc_ack = 1'b0;
      chk({name, "_vld_drop"}, {bus.acc_vld, bus.busy}, 0);
    end
  endtask

  vec_t vecs [7];
  int   stable_err;
  int   model_acc;
  bit   model_ovf;

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_in = '0; bus.acc_ack = 1'b0;
    for (int i = 0; i < 256; i++) prod_mem[i] = '0;

    vecs[0] = mk("n4_basic",   4,    3,    5,  -2,   7,   13, 0);
    vecs[1] = mk("n0_empty",   0,    0,    0,   0,   0,    0, 0);
    vecs[2] = mk("sat_pos",    2,  100,  100,   0,   0,  127, 1);
    vecs[3] = mk("after_sat",  2,    1,    1,   0,   0,    2, 0);
    vecs[4] = mk("sat_neg",    3, -100, -100,  50,   0,  -78, 1);
    vecs[5] = mk("n1_neg",     1,   -5,    0,   0,   0,   -5, 0);
    vecs[6] = mk("sat_recover",4,  127,    1, -100, -27,   0, 1);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.rd_en, bus.df_rdy, bus.acc_vld, bus.ovf, bus.acc_out, bus.rd_addr}, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      for (int i = 0; i < 4; i++) prod_mem[i] = 8'(vecs[k].p[i]);
      run_pass(vecs[k].name, vecs[k].n, vecs[k].exp_acc, vecs[k].exp_ovf, 1'b1);
    end

    // start and abort together: abort wins
    @(negedge clk);
    bus.num_in = 9'd3; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", {bus.busy, bus.rd_en}, 0);

    // abort on the second ISSUE cycle of N=8, then late products
    for (int i = 0; i < 8; i++) prod_mem[i] = 8'sd1;
    bus.num_in = 9'd8; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_issue", {bus.busy, bus.rd_en}, 2'b11);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_idle", {bus.busy, bus.rd_en, bus.df_rdy, bus.acc_vld}, 0);
    inj_rdy = 1'b1; inj_val = 8'sd50;
    repeat (3) @(negedge clk);
    inj_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_mu_ignored", bus.acc_out, 0);
    chk("late_mu_idle", {bus.busy, bus.acc_vld}, 0);
    prod_mem[0] = 8'sd9;
    run_pass("after_abort", 1, 9, 1'b0, 1'b1);

    // result held without ack; start in DONE ignored
    prod_mem[0] = 8'sd10; prod_mem[1] = 8'sd20;
    run_pass("hold", 2, 30, 1'b0, 1'b0);
    stable_err = 0;
    for (int c = 0; c < 10; c++) begin
      bus.start  = (c == 3);
      bus.num_in = 9'd0;
      @(posedge clk);
      @(negedge clk);
      if (!bus.acc_vld || bus.acc_out !== 8'sd30 || !bus.busy) stable_err++;
    end
    bus.start = 1'b0;
    chk("hold_stable", stable_err, 0);
    bus.acc_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_ack_idle", {bus.busy, bus.acc_vld}, 0);
    @(posedge clk);
    @(negedge clk);
    bus.acc_ack = 1'b0;
    chk("ack_without_vld", {bus.busy, bus.acc_vld}, 0);
    chk("acc_held_idle", bus.acc_out, 30);

    // asynchronous reset in DRAIN
    prod_mem[0] = 8'sd3; prod_mem[1] = 8'sd5; prod_mem[2] = -8'sd2; prod_mem[3] = 8'sd7;
    bus.num_in = 9'd4; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("in_drain", {bus.busy, bus.rd_en}, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {bus.busy, bus.rd_en, bus.df_rdy, bus.acc_vld, bus.ovf, bus.acc_out, bus.rd_addr}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // full-depth pass
    for (int i = 0; i < 256; i++) prod_mem[i] = 8'(((i * 37) % 11) - 5);
    model_acc = 0; model_ovf = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model_acc += int'(prod_mem[i]);
      if (model_acc > 127)       begin model_acc = 127;  model_ovf = 1'b1; end
      else if (model_acc < -128) begin model_acc = -128; model_ovf = 1'b1; end
    end
    run_pass("full_256", 256, model_acc, model_ovf, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
